// File: rtl/serial_paralelo_pkg.sv
// Shared definitions for the serial link: comma symbol, lock threshold and
// the receiver/transmitter state encoding (also reused by paralelo_serial).
package serial_paralelo_pkg;

    typedef logic [7:0] byte_t;

    // K28.5 comma, used as idle and as the alignment marker.
    localparam byte_t       COM_K28_5         = 8'hBC;
    localparam int unsigned COM_COUNT_DEFAULT = 4;

    typedef enum logic [1:0] {
        StSearch = 2'd0,
        StAlign  = 2'd1,
        StActive = 2'd2
    } link_state_e;

endpackage

// File: rtl/serial_paralelo_if.sv
// Serial-to-parallel link bundle.
//   data_in   : serial bit stream, MSB of each byte first
//   data_out  : recovered byte
//   valid_out : one-cycle qualifier for data_out
//   active    : byte alignment locked
// master = stream source / byte consumer side, slave = the deserializer.
interface serial_paralelo_if;

    logic                        data_in;
    serial_paralelo_pkg::byte_t  data_out;
    logic                        valid_out;
    logic                        active;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output active
    );

endinterface

// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver with comma-based byte alignment.
// Searches the bit stream for COM at any bit phase, then requires COM_COUNT
// consecutive byte-aligned COMs before locking. Once locked, every non-COM
// byte is presented on data_out with a one-cycle valid_out pulse; COM bytes
// are treated as idle. Lock is only lost through reset.
// Ports:
//   clk    : clock, all state on rising edge
//   reset  : synchronous, active-high reset
//   bus    : serial_paralelo_if.slave (data_in, data_out, valid_out, active)
module serial_paralelo
    import serial_paralelo_pkg::*;
#(
    parameter byte_t       COM       = COM_K28_5,
    parameter int unsigned COM_COUNT = COM_COUNT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    serial_paralelo_if.slave bus
);

    localparam int unsigned     CntW   = (COM_COUNT < 2) ? 1 : $clog2(COM_COUNT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(COM_COUNT);

    link_state_e     state_q, state_d;
    // Only the last seven bits are stored: together with data_in they form
    // the full 8-bit window, so the oldest bit never needs to be kept.
    logic [6:0]      shift_q, shift_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [CntW-1:0] com_cnt_q, com_cnt_d;
    byte_t           data_q, data_d;
    logic            valid_q, valid_d;
    logic            active_q;

    byte_t           next_byte;
    logic            is_com;
    logic            boundary;
    logic [CntW-1:0] cnt_inc;

    always_comb begin
        next_byte = {shift_q, bus.data_in};
        is_com    = (next_byte == COM);
        boundary  = (bit_cnt_q == 3'd7);
        cnt_inc   = com_cnt_q + CntW'(1);

        shift_d   = next_byte[6:0];
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + 3'd1;
        com_cnt_d = com_cnt_q;
        data_d    = data_q;
        valid_d   = 1'b0;

        unique case (state_q)
            StSearch: begin
                // Bit counter is parked until a COM fixes the byte phase.
                bit_cnt_d = '0;
                if (is_com) begin
                    com_cnt_d = CntW'(1);
                    state_d   = (COM_COUNT <= 1) ? StActive : StAlign;
                end
            end
            StAlign: begin
                if (boundary) begin
                    if (is_com) begin
                        com_cnt_d = (com_cnt_q == CntMax) ? com_cnt_q : cnt_inc;
                        if (com_cnt_d == CntMax) begin
                            state_d = StActive;
                        end
                    end else begin
                        com_cnt_d = '0;
                        state_d   = StSearch;
                    end
                end
            end
            StActive: begin
                // COM bytes are idle: no pulse, data_out keeps the last byte.
                if (boundary && !is_com) begin
                    data_d  = next_byte;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = StSearch;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StSearch;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            com_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            active_q  <= (state_d == StActive);
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.active    = active_q;

endmodule

// File: tb/tb_serial_paralelo.sv
// Testbench for serial_paralelo. Each scenario builds a bit stream, drives it
// one bit per clock, records the outputs after every edge and compares them
// with a stream-level reference model (comma search over the bit array).
module tb_serial_paralelo;
    import serial_paralelo_pkg::*;

    localparam byte_t COM       = COM_K28_5;
    localparam int    COM_COUNT = int'(COM_COUNT_DEFAULT);
    localparam int    MaxLen    = 512;

    logic clk = 1'b0;
    logic reset;

    serial_paralelo_if bus ();

    serial_paralelo #(
        .COM       (COM),
        .COM_COUNT (COM_COUNT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic  stim       [MaxLen];
    int    stim_len;
    logic  exp_valid  [MaxLen];
    logic  exp_active [MaxLen];
    byte_t exp_data   [MaxLen];
    logic  obs_valid  [MaxLen];
    logic  obs_active [MaxLen];
    byte_t obs_data   [MaxLen];

    task automatic clear_stim();
        stim_len = 0;
    endtask

    task automatic push_bit(input logic b);
        stim[stim_len] = b;
        stim_len++;
    endtask

    task automatic push_byte(input byte_t v);
        for (int i = 7; i >= 0; i--) push_bit(v[i]);
    endtask

    // Byte formed by the 8 most recent bits at edge e (zeros before the stream).
    function automatic byte_t byte_at(input int e);
        byte_t v = '0;
        for (int k = e - 7; k <= e; k++) v = {v[6:0], (k >= 0) ? stim[k] : 1'b0};
        return v;
    endfunction

    // Reference: find a COM at any bit position, then demand COM_COUNT-1 more
    // COMs every 8 bits; a miss restarts the search on the following bit.
    // After lock, every 8th bit closes a byte; non-COM bytes are emitted.
    task automatic model_stream();
        int    i, j, k, cnt, lock;
        byte_t held;
        for (int e = 0; e < stim_len; e++) begin
            exp_valid[e]  = 1'b0;
            exp_active[e] = 1'b0;
            exp_data[e]   = 8'h00;
        end
        lock = -1;
        i    = 0;
        while (lock < 0 && i < stim_len) begin
            j = i;
            while (j < stim_len && byte_at(j) != COM) j++;
            if (j >= stim_len) break;
            cnt = 1;
            k   = j;
            while (cnt < COM_COUNT && k + 8 < stim_len && byte_at(k + 8) == COM) begin
                k += 8;
                cnt++;
            end
            if (cnt == COM_COUNT) lock = k;
            else if (k + 8 < stim_len) i = k + 9;
            else break;
        end
        if (lock >= 0) begin
            held = 8'h00;
            for (int e = lock; e < stim_len; e++) begin
                exp_active[e] = 1'b1;
                if (e > lock && (e - lock) % 8 == 0 && byte_at(e) != COM) begin
                    held         = byte_at(e);
                    exp_valid[e] = 1'b1;
                end
                exp_data[e] = held;
            end
        end
    endtask

    task automatic drive_stream();
        for (int i = 0; i < stim_len; i++) begin
            bus.data_in = stim[i];
            @(posedge clk);
            #1;
            obs_valid[i]  = bus.valid_out;
            obs_active[i] = bus.active;
            obs_data[i]   = bus.data_out;
        end
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            bus.data_in = 1'($urandom);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bus.data_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({bus.active, bus.valid_out, bus.data_out} !== 10'h000) begin
                n_bad++;
                $display("FAIL reset cycle %0d: got act=%b val=%b data=%h, want 0/0/00",
                         i, bus.active, bus.valid_out, bus.data_out);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_aligned();
        byte_t want [4] = '{8'hFF, 8'hEE, 8'hDD, 8'hCC};
        apply_reset(2);
        clear_stim();
        repeat (4) push_byte(COM);
        for (int i = 0; i < 4; i++) push_byte(want[i]);
        drive_stream();
        model_stream();
        for (int e = 0; e < stim_len; e++) begin
            n_cmp++;
            if ({obs_active[e], obs_valid[e], obs_data[e]} !==
                {exp_active[e], exp_valid[e], exp_data[e]}) begin
                n_bad++;
                $display("FAIL aligned edge %0d: got act=%b val=%b data=%h, want %b/%b/%h", e,
                         obs_active[e], obs_valid[e], obs_data[e],
                         exp_active[e], exp_valid[e], exp_data[e]);
            end
        end
        n_cmp++;
        if (obs_active[30] !== 1'b0 || obs_active[31] !== 1'b1) begin
            n_bad++;
            $display("FAIL aligned_lock_edge: got act30=%b act31=%b, want 0 1",
                     obs_active[30], obs_active[31]);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({obs_valid[39 + 8 * i], obs_data[39 + 8 * i]} !== {1'b1, want[i]}) begin
                n_bad++;
                $display("FAIL aligned_byte%0d: got val=%b data=%h, want 1/%h", i,
                         obs_valid[39 + 8 * i], obs_data[39 + 8 * i], want[i]);
            end
        end
    endtask

    task automatic test_junk_phase();
        int n_valid = 0;
        apply_reset(2);
        clear_stim();
        push_bit(1'b1);
        push_bit(1'b0);
        push_bit(1'b1);
        repeat (4) push_byte(COM);
        push_byte(8'h77);
        drive_stream();
        model_stream();
        for (int e = 0; e < stim_len; e++) begin
            n_cmp++;
            if ({obs_active[e], obs_valid[e], obs_data[e]} !==
                {exp_active[e], exp_valid[e], exp_data[e]}) begin
                n_bad++;
                $display("FAIL junk_phase edge %0d: got act=%b val=%b data=%h, want %b/%b/%h", e,
                         obs_active[e], obs_valid[e], obs_data[e],
                         exp_active[e], exp_valid[e], exp_data[e]);
            end
            if (obs_valid[e] === 1'b1) n_valid++;
        end
        n_cmp++;
        if (n_valid != 1 || obs_valid[42] !== 1'b1 || obs_data[42] !== 8'h77) begin
            n_bad++;
            $display("FAIL junk_phase_out: got %0d pulses, val42=%b data42=%h, want 1 pulse 77",
                     n_valid, obs_valid[42], obs_data[42]);
        end
    endtask

    task automatic test_false_lock();
        int early_active = 0;
        apply_reset(2);
        clear_stim();
        repeat (3) push_byte(COM);
        push_byte(8'h55);
        repeat (4) push_byte(COM);
        push_byte(8'hAA);
        drive_stream();
        model_stream();
        for (int e = 0; e < stim_len; e++) begin
            n_cmp++;
            if ({obs_active[e], obs_valid[e], obs_data[e]} !==
                {exp_active[e], exp_valid[e], exp_data[e]}) begin
                n_bad++;
                $display("FAIL false_lock edge %0d: got act=%b val=%b data=%h, want %b/%b/%h", e,
                         obs_active[e], obs_valid[e], obs_data[e],
                         exp_active[e], exp_valid[e], exp_data[e]);
            end
            if (e < 63 && obs_active[e] !== 1'b0) early_active++;
        end
        n_cmp++;
        if (early_active != 0 || obs_active[63] !== 1'b1 ||
            {obs_valid[71], obs_data[71]} !== {1'b1, 8'hAA}) begin
            n_bad++;
            $display("FAIL false_lock_out: got early=%0d act63=%b val71=%b data71=%h, want 0 1 1 aa",
                     early_active, obs_active[63], obs_valid[71], obs_data[71]);
        end
    endtask

    task automatic test_com_in_active();
        apply_reset(2);
        clear_stim();
        repeat (4) push_byte(COM);
        push_byte(8'hBB);
        push_byte(COM);
        push_byte(8'hAA);
        drive_stream();
        model_stream();
        for (int e = 0; e < stim_len; e++) begin
            n_cmp++;
            if ({obs_active[e], obs_valid[e], obs_data[e]} !==
                {exp_active[e], exp_valid[e], exp_data[e]}) begin
                n_bad++;
                $display("FAIL com_in_active edge %0d: got act=%b val=%b data=%h, want %b/%b/%h", e,
                         obs_active[e], obs_valid[e], obs_data[e],
                         exp_active[e], exp_valid[e], exp_data[e]);
            end
        end
        n_cmp++;
        if ({obs_valid[39], obs_data[39], obs_valid[47], obs_data[47], obs_valid[55], obs_data[55]}
            !== {1'b1, 8'hBB, 1'b0, 8'hBB, 1'b1, 8'hAA}) begin
            n_bad++;
            $display("FAIL com_idle_slot: got %b/%h %b/%h %b/%h, want 1/bb 0/bb 1/aa",
                     obs_valid[39], obs_data[39], obs_valid[47], obs_data[47],
                     obs_valid[55], obs_data[55]);
        end
    endtask

    task automatic test_reset_mid_active();
        int early_valid = 0;
        apply_reset(2);
        clear_stim();
        repeat (4) push_byte(COM);
        push_byte(8'hAA);
        push_bit(1'b1);
        push_bit(1'b0);
        push_bit(1'b0);
        drive_stream();
        n_cmp++;
        if (obs_active[stim_len - 1] !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_reset_prelock: got act=%b, want 1", obs_active[stim_len - 1]);
        end
        apply_reset(1);
        n_cmp++;
        if ({bus.active, bus.valid_out, bus.data_out} !== 10'h000) begin
            n_bad++;
            $display("FAIL mid_reset_clear: got act=%b val=%b data=%h, want 0/0/00",
                     bus.active, bus.valid_out, bus.data_out);
        end
        clear_stim();
        repeat (3) push_byte(8'h88);
        repeat (4) push_byte(COM);
        push_byte(8'h88);
        drive_stream();
        model_stream();
        for (int e = 0; e < stim_len; e++) begin
            n_cmp++;
            if ({obs_active[e], obs_valid[e], obs_data[e]} !==
                {exp_active[e], exp_valid[e], exp_data[e]}) begin
                n_bad++;
                $display("FAIL mid_reset edge %0d: got act=%b val=%b data=%h, want %b/%b/%h", e,
                         obs_active[e], obs_valid[e], obs_data[e],
                         exp_active[e], exp_valid[e], exp_data[e]);
            end
            if (e < 63 && obs_valid[e] !== 1'b0) early_valid++;
        end
        n_cmp++;
        if (early_valid != 0 || obs_active[55] !== 1'b1 ||
            {obs_valid[63], obs_data[63]} !== {1'b1, 8'h88}) begin
            n_bad++;
            $display("FAIL mid_reset_relock: got early=%0d act55=%b val63=%b data63=%h, want 0 1 1 88",
                     early_valid, obs_active[55], obs_valid[63], obs_data[63]);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            apply_reset(2);
            clear_stim();
            repeat ($urandom_range(7, 0)) push_bit(1'($urandom));
            for (int b = 0; b < 14; b++) begin
                if ($urandom_range(3, 0) == 0) repeat (COM_COUNT) push_byte(COM);
                else if ($urandom_range(1, 0) == 0) push_byte(COM);
                else push_byte(8'($urandom));
            end
            drive_stream();
            model_stream();
            for (int e = 0; e < stim_len; e++) begin
                n_cmp++;
                if ({obs_active[e], obs_valid[e], obs_data[e]} !==
                    {exp_active[e], exp_valid[e], exp_data[e]}) begin
                    n_bad++;
                    $display("FAIL random it%0d edge %0d: got act=%b val=%b data=%h, want %b/%b/%h",
                             it, e, obs_active[e], obs_valid[e], obs_data[e],
                             exp_active[e], exp_valid[e], exp_data[e]);
                end
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        bus.data_in = 1'b0;
        test_reset();
        test_aligned();
        test_junk_phase();
        test_false_lock();
        test_com_in_active();
        test_reset_mid_active();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
